shift_rotate_unit: RTL and testbench

SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

---
 rtl/shift_rotate_pkg.sv | 15 +
 rtl/shift_rotate_unit_if.sv | 25 ++
 rtl/shift_rotate_core.sv | 58 +++++
 rtl/shift_rotate_unit.sv | 41 ++++
 tb/tb_shift_rotate_unit.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/shift_rotate_pkg.sv
// Shared constants and op encodings for the shift/rotate unit.
package shift_rotate_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_ROL  = 3'b011,
    OP_PASS = 3'b100,
    OP_ROR  = 3'b111
  } op_e;

endpackage

// File: rtl/shift_rotate_unit_if.sv
// Operand/result bundle between a requester and the shift/rotate unit.
interface shift_rotate_unit_if
  import shift_rotate_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] b;
  logic [2:0]         op;
  logic [WIDTH-1:0]   shift_rotate_unit_out;
  logic               out_valid;

  modport master (
    output in_valid, a, b, op,
    input  shift_rotate_unit_out, out_valid
  );

  modport slave (
    input  in_valid, a, b, op,
    output shift_rotate_unit_out, out_valid
  );
endinterface

// File: rtl/shift_rotate_core.sv
// Combinational log2-stage barrel shifter; direction, fill and rotate decoded from op.
module shift_rotate_core
  import shift_rotate_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [2:0]         op,
  output logic [WIDTH-1:0]   result
);

  logic shift_en, left, rotate, arith, zero;

  always_comb begin
    shift_en = 1'b1;
    left     = 1'b0;
    rotate   = 1'b0;
    arith    = 1'b0;
    zero     = 1'b0;
    case (op)
      OP_SLL:  left = 1'b1;
      OP_SRL:  ;
      OP_SRA:  arith = 1'b1;
      OP_ROL:  begin left = 1'b1; rotate = 1'b1; end
      OP_PASS: shift_en = 1'b0;
      OP_ROR:  rotate = 1'b1;
      default: begin shift_en = 1'b0; zero = 1'b1; end
    endcase
  end

  logic             fill;
  logic [WIDTH-1:0] x;
  int unsigned      s;

  assign fill = arith & a[WIDTH-1];

  // Stage i moves the word by 2**i when b[i] is set.
  always_comb begin
    x = a;
    s = 0;
    for (int i = 0; i < int'(SHAMT_W); i++) begin
      s = 32'd1 << i;
      if (shift_en && b[i]) begin
        if (left) begin
          x = rotate ? ((x << s) | (x >> (WIDTH - s))) : (x << s);
        end else if (rotate) begin
          x = (x >> s) | (x << (WIDTH - s));
        end else begin
          x = (x >> s) | (fill ? ~({WIDTH{1'b1}} >> s) : '0);
        end
      end
    end
    result = zero ? '0 : x;
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Shift/rotate unit: combinational core with a single registered output stage.
module shift_rotate_unit
  import shift_rotate_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_rotate_unit_if.slave  bus
);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  shift_rotate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.a),
    .b      (bus.b),
    .op     (bus.op),
    .result (result)
  );

  // Result only updates on accepted inputs; otherwise the last value holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= result;
      end
    end
  end

  assign bus.shift_rotate_unit_out = out_q;
  assign bus.out_valid             = valid_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed self-checking bench for shift_rotate_unit.
module tb_shift_rotate_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  shift_rotate_unit_if #(.WIDTH(32)) bus ();

  shift_rotate_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] b,
                                            input logic [2:0] op);
    logic [63:0] tmp;
    case (op)
      3'b000:  return a << b;
      3'b001:  return a >> b;
      3'b010:  return $signed(a) >>> b;
      3'b011:  begin tmp = {a, a} << b; return tmp[63:32]; end
      3'b100:  return a;
      3'b111:  begin tmp = {a, a} >> b; return tmp[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  // Present one operation at the falling edge, check it one edge later.
  task automatic apply(input string tag, input logic [31:0] a, input logic [4:0] b,
                       input logic [2:0] op, input logic [31:0] exp, input bit chk_valid);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    @(posedge clk);
    #1;
    check_eq(tag, bus.shift_rotate_unit_out, exp);
    if (chk_valid) check_eq({tag, "_valid"}, {31'b0, bus.out_valid}, 32'h1);
  endtask

  logic [31:0] pats [2];

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = '0;
    #1;
    check_eq("reset_out", bus.shift_rotate_unit_out, 32'h0);
    check_eq("reset_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("sll3",    32'hF9C9C9C9, 5'd3,  3'b000, 32'hCE4E4E48, 1'b1);
    apply("srl4",    32'hF9C9C9C9, 5'd4,  3'b001, 32'h0F9C9C9C, 1'b1);
    apply("sra20",   32'hF9C9C9C9, 5'd20, 3'b010, 32'hFFFFFF9C, 1'b1);
    apply("rol20",   32'hF9C9C9C9, 5'd20, 3'b011, 32'h9C9F9C9C, 1'b1);
    apply("ror20",   32'hF9800000, 5'd20, 3'b111, 32'h00000F98, 1'b1);
    apply("sll_m4",  32'hF0000000, 5'd28, 3'b000, 32'h00000000, 1'b1);
    apply("sll_20",  32'h00000014, 5'd3,  3'b000, 32'h000000A0, 1'b1);
    apply("pass",    32'hDEADBEEF, 5'd7,  3'b100, 32'hDEADBEEF, 1'b1);
    apply("rsv101",  32'hDEADBEEF, 5'd7,  3'b101, 32'h00000000, 1'b1);
    apply("rsv110",  32'hDEADBEEF, 5'd7,  3'b110, 32'h00000000, 1'b1);
    apply("sra_b0",  32'h80000001, 5'd0,  3'b010, 32'h80000001, 1'b1);
    apply("ror_b0",  32'h80000001, 5'd0,  3'b111, 32'h80000001, 1'b1);
    apply("sra31",   32'h80000000, 5'd31, 3'b010, 32'hFFFFFFFF, 1'b1);
    apply("rol31",   32'h80000001, 5'd31, 3'b011, 32'hC0000000, 1'b1);

    // Hold: idle cycle keeps the last result and drops out_valid.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'h12345678;
    bus.op       = 3'b100;
    @(posedge clk);
    #1;
    check_eq("hold_out", bus.shift_rotate_unit_out, 32'hC0000000);
    check_eq("hold_valid", {31'b0, bus.out_valid}, 32'h0);

    // Back-to-back sweep against the reference model.
    pats[0] = 32'hF9C9C9C9;
    pats[1] = 32'h12345678;
    for (int p = 0; p < 2; p++) begin
      for (int o = 0; o < 8; o++) begin
        for (int sh = 0; sh < 32; sh++) begin
          apply($sformatf("sweep_p%0d_op%0d_b%0d", p, o, sh), pats[p], 5'(sh), 3'(o),
                ref_model(pats[p], 5'(sh), 3'(o)), 1'b0);
        end
      end
    end
    check_eq("sweep_valid", {31'b0, bus.out_valid}, 32'h1);

    // Asynchronous reset between edges while a result is valid.
    apply("pre_rst", 32'h0000F00F, 5'd4, 3'b000, 32'h000F00F0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", bus.shift_rotate_unit_out, 32'h0);
    check_eq("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_out", bus.shift_rotate_unit_out, 32'h0);
      check_eq("post_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    end
    apply("after_rst", 32'h00000001, 5'd31, 3'b000, 32'h80000000, 1'b1);

    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("final_idle_valid", {31'b0, bus.out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
